sel_scan_reg: RTL and testbench

//  Registered, enable-gated N-channel selector. Successor to the 2-input gated bit selector:
//  NUM_CH channels of WIDTH bits, manual select or automatic round-robin scan, registered out.

---
 rtl/sel_scan_reg_pkg.sv | 8 +
 rtl/sel_scan_reg_if.sv | 19 +
 rtl/scan_tick_gen.sv | 16 +
 rtl/sel_scan_reg.sv | 44 ++++
 tb/tb_sel_scan_reg.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sel_scan_reg_pkg.sv
// sel_scan_reg_pkg: shared mode encodings and select-width helper for the channel selector
package sel_scan_reg_pkg;
  localparam logic SEL_MODE_MANUAL = 1'b0;
  localparam logic SEL_MODE_SCAN = 1'b1;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sel_scan_reg_if.sv
// sel_scan_reg_if: control, channel data and registered outputs of the channel selector
interface sel_scan_reg_if
  import sel_scan_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 4
);
  localparam int SELW = sel_w(NUM_CH);
  logic en;
  logic mode;
  logic [SELW-1:0] sel;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  logic ch_change;
  modport master (output en, mode, sel, ch_data, input out_data, out_ch, out_valid, ch_change);
  modport slave (input en, mode, sel, ch_data, output out_data, out_ch, out_valid, ch_change);
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: prescaler pulsing tick on its last count of SCAN_DIV while run is high
module scan_tick_gen #(
  parameter int SCAN_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = run && cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!run || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sel_scan_reg.sv
// sel_scan_reg: registered enable-gated N-channel selector with manual select or round-robin scan
module sel_scan_reg
  import sel_scan_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 4,
  parameter int SCAN_DIV = 8
) (
  input logic clk,
  input logic rst_n,
  sel_scan_reg_if.slave bus
);
  localparam int SELW = sel_w(NUM_CH);
  logic tick;
  logic scan;
  logic [SELW-1:0] next_ch;
  assign scan = bus.mode == SEL_MODE_SCAN;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .run(bus.en && scan),
    .tick(tick)
  );
  // out-of-range manual selects hold the current channel
  always_comb
    next_ch = scan ? (tick ? (bus.out_ch == SELW'(NUM_CH - 1) ? '0 : bus.out_ch + 1'b1) : bus.out_ch)
                   : ({1'b0, bus.sel} < (SELW + 1)'(NUM_CH) ? bus.sel : bus.out_ch);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_ch <= '0;
      bus.out_valid <= 1'b0;
      bus.ch_change <= 1'b0;
    end else if (!bus.en) begin
      bus.out_data <= '0;
      bus.out_valid <= 1'b0;
      bus.ch_change <= 1'b0;
    end else begin
      bus.out_ch <= next_ch;
      bus.out_data <= bus.ch_data[int'(next_ch)*WIDTH +: WIDTH];
      bus.out_valid <= 1'b1;
      bus.ch_change <= next_ch != bus.out_ch;
    end
endmodule

// File: tb/tb_sel_scan_reg.sv
// tb_sel_scan_reg: directed scenarios plus random stimulus against a behavioural selector model
module tb_sel_scan_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  localparam int NCH [2] = '{4, 3};
  localparam int DIV [2] = '{3, 1};
  localparam int W [2] = '{4, 8};
  int m_ch [2];
  int m_cnt [2];
  int m_data [2];
  bit m_valid [2];
  bit m_chg [2];

  sel_scan_reg_if #(.NUM_CH(4), .WIDTH(4)) b0 ();
  sel_scan_reg_if #(.NUM_CH(3), .WIDTH(8)) b1 ();
  sel_scan_reg #(.NUM_CH(4), .WIDTH(4), .SCAN_DIV(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  sel_scan_reg #(.NUM_CH(3), .WIDTH(8), .SCAN_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ch[k] = 0;
      m_cnt[k] = 0;
      m_data[k] = 0;
      m_valid[k] = 0;
      m_chg[k] = 0;
    end
  endfunction

  function automatic void model(int k, bit en, bit mode, int sel, longint data);
    int nxt;
    if (!en) begin
      m_cnt[k] = 0;
      m_data[k] = 0;
      m_valid[k] = 0;
      m_chg[k] = 0;
      return;
    end
    nxt = m_ch[k];
    if (mode) begin
      if (m_cnt[k] == DIV[k] - 1) begin
        m_cnt[k] = 0;
        nxt = (m_ch[k] + 1) % NCH[k];
      end else m_cnt[k]++;
    end else begin
      m_cnt[k] = 0;
      if (sel < NCH[k]) nxt = sel;
    end
    m_chg[k] = nxt != m_ch[k];
    m_ch[k] = nxt;
    m_data[k] = int'((data >> (nxt * W[k])) & ((64'd1 << W[k]) - 1));
    m_valid[k] = 1;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    if (rst_n) begin
      model(0, b0.en, b0.mode, int'(b0.sel), longint'(b0.ch_data));
      model(1, b1.en, b1.mode, int'(b1.sel), longint'(b1.ch_data));
    end
    #1;
  endtask

  task automatic test_reset();
    b0.en = 1; b0.mode = 1; b0.ch_data = 16'($urandom());
    b1.en = 1; b1.mode = 1; b1.ch_data = 24'($urandom());
    repeat (5) edge_step();
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change} !== 8'h0) begin
      errors++;
      $display("FAIL reset_dut0: got %h expected 00", {b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change});
    end
    checks++;
    if ({b1.out_data, b1.out_ch, b1.out_valid, b1.ch_change} !== 12'h0) begin
      errors++;
      $display("FAIL reset_dut1: got %h expected 000", {b1.out_data, b1.out_ch, b1.out_valid, b1.ch_change});
    end
    #2 rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      checks++;
      if (b0.out_ch !== 2'(i / 3)) begin
        errors++;
        $display("FAIL reset_restart edge %0d: out_ch %0d expected %0d", i, b0.out_ch, i / 3);
      end
    end
  endtask

  task automatic test_manual();
    b0.mode = 0; b0.sel = 2; b0.ch_data = 16'hD5A3;
    edge_step();
    checks++;
    if ({b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change} !== {4'h5, 2'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL manual_sel2: got data=%h ch=%0d v=%b chg=%b expected 5/2/1/1", b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change);
    end
    edge_step();
    checks++;
    if ({b0.out_data, b0.ch_change} !== {4'h5, 1'b0}) begin
      errors++;
      $display("FAIL manual_hold: got data=%h chg=%b expected 5/0", b0.out_data, b0.ch_change);
    end
  endtask

  task automatic test_out_of_range();
    b1.mode = 0; b1.sel = 1; b1.ch_data = 24'hC3_5A_96;
    edge_step();
    checks++;
    if (b1.out_ch !== 2'd1 || b1.out_data !== 8'h5A) begin
      errors++;
      $display("FAIL oor_sel1: got ch=%0d data=%h expected 1/5a", b1.out_ch, b1.out_data);
    end
    b1.sel = 3;
    edge_step();
    checks++;
    if ({b1.out_ch, b1.ch_change, b1.out_data} !== {2'd1, 1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL oor_sel3: got ch=%0d chg=%b data=%h expected 1/0/5a", b1.out_ch, b1.ch_change, b1.out_data);
    end
  endtask

  task automatic test_scan();
    logic [15:0] d;
    d = 16'hD5A3;
    b0.mode = 0; b0.sel = 0; b0.ch_data = d;
    edge_step();
    b0.mode = 1;
    for (int i = 1; i <= 12; i++) begin
      edge_step();
      checks++;
      if ({b0.out_ch, b0.ch_change, b0.out_data} !== {2'((i / 3) % 4), i % 3 == 0, d[((i / 3) % 4) * 4 +: 4]}) begin
        errors++;
        $display("FAIL scan edge %0d: got ch=%0d chg=%b data=%h expected ch=%0d chg=%b", i, b0.out_ch, b0.ch_change, b0.out_data, (i / 3) % 4, i % 3 == 0);
      end
    end
  endtask

  task automatic test_en_scan();
    repeat (6) edge_step();
    b0.en = 0;
    edge_step();
    checks++;
    if ({b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change} !== {4'h0, 2'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL disable: got data=%h ch=%0d v=%b chg=%b expected 0/2/0/0", b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change);
    end
    b0.en = 1;
    for (int i = 1; i <= 3; i++) begin
      edge_step();
      checks++;
      if ({b0.out_ch, b0.ch_change, b0.out_valid} !== {i == 3 ? 2'd3 : 2'd2, i == 3, 1'b1}) begin
        errors++;
        $display("FAIL reenable edge %0d: got ch=%0d chg=%b v=%b expected ch=%0d", i, b0.out_ch, b0.ch_change, b0.out_valid, i == 3 ? 3 : 2);
      end
    end
  endtask

  task automatic test_manual_to_scan();
    b0.mode = 0; b0.sel = 1;
    edge_step();
    b0.mode = 1; b0.sel = 3;
    for (int i = 1; i <= 3; i++) begin
      edge_step();
      checks++;
      if (b0.out_ch !== (i == 3 ? 2'd2 : 2'd1)) begin
        errors++;
        $display("FAIL man_to_scan edge %0d: out_ch %0d expected %0d", i, b0.out_ch, i == 3 ? 2 : 1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 0;
        model_reset();
        #2 rst_n = 1;
      end
      b0.en = $urandom_range(0, 7) != 0;
      b1.en = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 7) == 0) b0.mode = ~b0.mode;
      if ($urandom_range(0, 7) == 0) b1.mode = ~b1.mode;
      b0.sel = 2'($urandom_range(0, 3));
      b1.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b0.ch_data = 16'($urandom());
      if ($urandom_range(0, 3) == 0) b1.ch_data = 24'($urandom());
      edge_step();
      checks++;
      if ({b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change} !== {4'(m_data[0]), 2'(m_ch[0]), m_valid[0], m_chg[0]}) begin
        errors++;
        $display("FAIL random_dut0 cyc %0d: got data=%h ch=%0d v=%b chg=%b expected data=%h ch=%0d v=%b chg=%b", n, b0.out_data, b0.out_ch, b0.out_valid, b0.ch_change, m_data[0], m_ch[0], m_valid[0], m_chg[0]);
      end
      checks++;
      if ({b1.out_data, b1.out_ch, b1.out_valid, b1.ch_change} !== {8'(m_data[1]), 2'(m_ch[1]), m_valid[1], m_chg[1]}) begin
        errors++;
        $display("FAIL random_dut1 cyc %0d: got data=%h ch=%0d v=%b chg=%b expected data=%h ch=%0d v=%b chg=%b", n, b1.out_data, b1.out_ch, b1.out_valid, b1.ch_change, m_data[1], m_ch[1], m_valid[1], m_chg[1]);
      end
    end
  endtask

  initial begin
    b0.en = 0; b0.mode = 0; b0.sel = 0; b0.ch_data = '0;
    b1.en = 0; b1.mode = 0; b1.sel = 0; b1.ch_data = '0;
    model_reset();
    #12 rst_n = 1;
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan();
    test_en_scan();
    test_manual_to_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
